// File: rtl/periph_tx_arbiter.sv
// Round-robin merge of peripheral upstream packets into the single USB TX packet stream.
// The address field of each forwarded packet is replaced with the index of its source slot.
module periph_tx_arbiter #(
   // Defaults mirror lycan::num_peripherals, lycan::usb_packet_width, lycan::periph_address_width
   parameter int NUM_PERIPHERALS = 8,
   parameter int PACKET_WIDTH    = 32,
   parameter int ADDR_WIDTH      = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_PERIPHERALS-1:0]              periph_valid,
   input  logic [NUM_PERIPHERALS*PACKET_WIDTH-1:0] periph_data,
   output logic [NUM_PERIPHERALS-1:0]              periph_ready,
   output logic                                    tx_valid,
   output logic [PACKET_WIDTH-1:0]                 tx_data,
   input  logic                                    tx_ready,
   output logic [ADDR_WIDTH-1:0]                   last_grant
);

   localparam int PAY_W = PACKET_WIDTH - ADDR_WIDTH;

   if (NUM_PERIPHERALS > 2**ADDR_WIDTH) begin : g_bad_cfg
      $error("periph_tx_arbiter: NUM_PERIPHERALS exceeds 2**ADDR_WIDTH");
   end

   logic [PAY_W-1:0]      payload_w [NUM_PERIPHERALS];
   logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] unused_addr_bits;

   for (genvar g = 0; g < NUM_PERIPHERALS; g++) begin : g_slot
      assign payload_w[g] = periph_data[g*PACKET_WIDTH +: PAY_W];
      assign unused_addr_bits[g*ADDR_WIDTH +: ADDR_WIDTH] =
         periph_data[g*PACKET_WIDTH+PAY_W +: ADDR_WIDTH];
   end

   logic                    tx_valid_q, tx_valid_d;
   logic [PACKET_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [ADDR_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic                    load;
   logic                    found;
   logic [ADDR_WIDTH-1:0]   grant_idx;
   logic [PAY_W-1:0]        grant_pay;
   logic [NUM_PERIPHERALS-1:0] ready_d;

   assign load = !tx_valid_q || tx_ready;

   // Search starts one past the last grant so every slot gets its turn.
   always_comb begin
      int                  idx_int;
      logic [ADDR_WIDTH-1:0] idx_a;
      found     = 1'b0;
      grant_idx = '0;
      grant_pay = '0;
      idx_int   = 0;
      idx_a     = '0;
      for (int k = 1; k <= NUM_PERIPHERALS; k++) begin
         idx_int = (int'(last_grant_q) + k) % NUM_PERIPHERALS;
         idx_a   = ADDR_WIDTH'(idx_int);
         if (!found && periph_valid[idx_a]) begin
            found     = 1'b1;
            grant_idx = idx_a;
            grant_pay = payload_w[idx_a];
         end
      end
   end

   always_comb begin
      ready_d = '0;
      if (!rst && load && found) begin
         ready_d[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      last_grant_d = last_grant_q;
      if (load) begin
         tx_valid_d = found;
         if (found) begin
            tx_data_d    = {grant_idx, grant_pay};
            last_grant_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         last_grant_q <= ADDR_WIDTH'(NUM_PERIPHERALS - 1);
      end else begin
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign periph_ready = ready_d;
   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;
   assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Directed bench for periph_tx_arbiter: reset, address stamping, rotation, backpressure,
// wrap-around priority and reset while stalled.
module tb_periph_tx_arbiter;

   localparam int N  = 8;
   localparam int PW = 32;
   localparam int AW = 3;

   logic            clk;
   logic            rst;
   logic [N-1:0]    periph_valid;
   logic [N*PW-1:0] periph_data;
   logic [N-1:0]    periph_ready;
   logic            tx_valid;
   logic [PW-1:0]   tx_data;
   logic            tx_ready;
   logic [AW-1:0]   last_grant;

   logic [PW-1:0]   slot_m [N];
   int              n_checks;
   int              n_fail;

   periph_tx_arbiter #(
      .NUM_PERIPHERALS(N),
      .PACKET_WIDTH   (PW),
      .ADDR_WIDTH     (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .periph_valid(periph_valid),
      .periph_data (periph_data),
      .periph_ready(periph_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .last_grant  (last_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] stamped(input int i);
      logic [PW-1:0] s;
      s = slot_m[i];
      return {3'(i), s[PW-AW-1:0]};
   endfunction

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      tx_ready     = 1'b1;
      periph_valid = '0;
      for (int i = 0; i < N; i++) begin
         slot_m[i] = 32'hE000_1000 + 32'(i);
      end
      slot_m[5] = 32'hFFFF_1234;
      for (int i = 0; i < N; i++) begin
         periph_data[i*PW +: PW] = slot_m[i];
      end

      // Reset held three cycles
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_tx_valid", 32'(tx_valid), 32'h0);
         check("rst_last_grant", 32'(last_grant), 32'h7);
         check("rst_ready", 32'(periph_ready), 32'h0);
         check("rst_tx_data", tx_data, 32'h0);
      end
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         check("idle_tx_valid", 32'(tx_valid), 32'h0);
         check("idle_ready", 32'(periph_ready), 32'h0);
         check("idle_last_grant", 32'(last_grant), 32'h7);
      end

      // Single requester on slot 5, address field stamped to 101
      periph_valid = 8'h20;
      #1;
      check("single_ready", 32'(periph_ready), 32'h20);
      step();
      check("single_tx_valid", 32'(tx_valid), 32'h1);
      check("single_tx_data", tx_data, 32'hBFFF_1234);
      check("single_last_grant", 32'(last_grant), 32'h5);
      periph_valid = 8'h00;
      #1;
      check("single_drop_ready", 32'(periph_ready), 32'h0);
      step();
      check("single_empty_valid", 32'(tx_valid), 32'h0);
      check("single_hold_data", tx_data, 32'hBFFF_1234);
      check("single_keep_grant", 32'(last_grant), 32'h5);

      // Return pointer to reset value, then all slots request
      rst = 1'b1;
      step();
      rst = 1'b0;
      periph_valid = 8'hFF;
      for (int c = 0; c < 16; c++) begin
         step();
         check("rr_tx_valid", 32'(tx_valid), 32'h1);
         check("rr_tx_data", tx_data, stamped(c % N));
      end
      periph_valid = 8'h00;
      step();
      check("rr_end_valid", 32'(tx_valid), 32'h0);
      check("rr_end_grant", 32'(last_grant), 32'h7);

      // Backpressure: grant 2, stall four cycles with 2 and 3 requesting
      periph_valid = 8'h04;
      step();
      check("bp_first_data", tx_data, 32'h4000_1002);
      periph_valid = 8'h0C;
      tx_ready     = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("bp_ready_zero", 32'(periph_ready), 32'h0);
         step();
         check("bp_valid_held", 32'(tx_valid), 32'h1);
         check("bp_data_held", tx_data, 32'h4000_1002);
         check("bp_grant_held", 32'(last_grant), 32'h2);
      end
      tx_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(periph_ready), 32'h08);
      step();
      check("bp_next_data", tx_data, 32'h6000_1003);
      check("bp_next_grant", 32'(last_grant), 32'h3);
      periph_valid = 8'h00;
      step();
      check("bp_drain_valid", 32'(tx_valid), 32'h0);

      // Wrap-around: pointer at 6, requests on 0 and 6
      periph_valid = 8'h40;
      step();
      check("wrap_setup_grant", 32'(last_grant), 32'h6);
      periph_valid = 8'h41;
      #1;
      check("wrap_ready0", 32'(periph_ready), 32'h01);
      step();
      check("wrap_data0", tx_data, 32'h0000_1000);
      check("wrap_grant0", 32'(last_grant), 32'h0);
      check("wrap_ready6", 32'(periph_ready), 32'h40);
      step();
      check("wrap_data6", tx_data, 32'hC000_1006);
      periph_valid = 8'h81;
      #1;
      check("wrap_ready7", 32'(periph_ready), 32'h80);
      step();
      check("wrap_data7", tx_data, 32'hE000_1007);
      check("wrap_grant7", 32'(last_grant), 32'h7);

      // Reset while a packet is stalled downstream
      periph_valid = 8'h02;
      step();
      check("stall_data", tx_data, 32'h2000_1001);
      tx_ready     = 1'b0;
      periph_valid = 8'h00;
      step();
      check("stall_valid", 32'(tx_valid), 32'h1);
      rst = 1'b1;
      #1;
      check("stall_rst_ready", 32'(periph_ready), 32'h0);
      step();
      check("stall_rst_valid", 32'(tx_valid), 32'h0);
      check("stall_rst_grant", 32'(last_grant), 32'h7);
      rst      = 1'b0;
      tx_ready = 1'b1;
      step();
      check("stall_never_sent", 32'(tx_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
